// File: rtl/sd_pkg.sv
// -----------------------------------------------------------------------------
// sd_pkg
// Shared definitions for the SPI-mode SD card blocks (command sender,
// response receiver, init FSM).
//   - sd_rx_state_t : response receiver FSM states
//   - R1 bit positions, response widths, timeout fill value
//   - r1_err_flag() : OR of the R1 error flags (idle bit excluded)
// -----------------------------------------------------------------------------
package sd_pkg;

    // Response receiver FSM states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HUNT  = 3'd1,
        R1    = 3'd2,
        EXTRA = 3'd3,
        DONE  = 3'd4
    } sd_rx_state_t;

    // Response geometry: R1 occupies the top byte, trailing word below it
    localparam int R1_W    = 32'd8;
    localparam int EXTRA_W = 32'd32;
    localparam int RESP_W  = 32'd40;
    localparam int R1_MSB  = RESP_W - 32'd1;
    localparam int R1_LSB  = RESP_W - R1_W;

    // R1 bit positions (bit 7 is the start bit and always 0)
    localparam int R1_BIT_IDLE        = 32'd0;
    localparam int R1_BIT_ERASE_RESET = 32'd1;
    localparam int R1_BIT_ILLEGAL_CMD = 32'd2;
    localparam int R1_BIT_CRC_ERR     = 32'd3;
    localparam int R1_BIT_ERASE_SEQ   = 32'd4;
    localparam int R1_BIT_ADDR_ERR    = 32'd5;
    localparam int R1_BIT_PARAM_ERR   = 32'd6;

    // Value reported in resp when no start bit arrives in time
    localparam logic [RESP_W-1:0] RESP_TIMEOUT_FILL = 40'hFF_FFFF_FFFF;

    // Any error flag set in an R1 byte; the idle bit is a status, not an error
    function automatic logic r1_err_flag(input logic [R1_W-1:0] r1);
        r1_err_flag = r1[R1_BIT_PARAM_ERR]   | r1[R1_BIT_ADDR_ERR]   |
                      r1[R1_BIT_ERASE_SEQ]   | r1[R1_BIT_CRC_ERR]    |
                      r1[R1_BIT_ILLEGAL_CMD] | r1[R1_BIT_ERASE_RESET];
    endfunction

endpackage

// File: rtl/sd_resp_rx_if.sv
// -----------------------------------------------------------------------------
// sd_resp_rx_if
// Handshake between the init/control FSM (master) and the SD response
// receiver (slave).
//   arm          master->slave  one-cycle strobe, start hunting
//   long_resp    master->slave  sampled on arm: 0=R1, 1=R1+32 bits
//   busy         slave->master  receiver occupied
//   resp_valid   slave->master  one-cycle pulse, resp captured
//   resp_timeout slave->master  one-cycle pulse, no start bit in time
//   resp[39:0]   slave->master  {R1, trailing word}
//   r1_err       slave->master  only with SD_RESP_R1_ERRCHK_EN defined
// -----------------------------------------------------------------------------
interface sd_resp_rx_if;
    import sd_pkg::*;

    logic              arm;
    logic              long_resp;
    logic              busy;
    logic              resp_valid;
    logic              resp_timeout;
    logic [RESP_W-1:0] resp;
`ifdef SD_RESP_R1_ERRCHK_EN
    logic              r1_err;
`endif

    modport master (
        output arm, long_resp,
`ifdef SD_RESP_R1_ERRCHK_EN
        input  r1_err,
`endif
        input  busy, resp_valid, resp_timeout, resp
    );

    modport slave (
        input  arm, long_resp,
`ifdef SD_RESP_R1_ERRCHK_EN
        output r1_err,
`endif
        output busy, resp_valid, resp_timeout, resp
    );

endinterface

// File: rtl/sd_edge_sync.sv
// -----------------------------------------------------------------------------
// sd_edge_sync
// STAGES-deep synchroniser with rising-edge detect. Two instances of equal
// depth keep sclk and miso aligned cycle for cycle.
//   clk   in   system clock
//   rst   in   synchronous, active-high reset
//   din   in   asynchronous input
//   q     out  synchronised level (last stage)
//   rise  out  high for one clk when q goes 0 -> 1
// -----------------------------------------------------------------------------
module sd_edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic q,
    output logic rise
);

    logic [STAGES-1:0] sync_r;
    logic              prev_r;

    // Shift the input through the synchroniser chain and keep the previous level
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= {STAGES{1'b0}};
            prev_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], din};
            prev_r <= sync_r[STAGES-1];
        end
    end

    assign q    = sync_r[STAGES-1];
    assign rise = sync_r[STAGES-1] & ~prev_r;

endmodule

// File: rtl/sd_resp_rx.sv
// -----------------------------------------------------------------------------
// sd_resp_rx
// SPI-mode SD response receiver. Passively watches sclk/miso, hunts for the
// response start bit and captures R1 or R1+32 bits (R3/R7). Never drives the
// bus.
//   clk    in   system clock (> 4x sclk)
//   rst    in   synchronous, active-high reset
//   sclk   in   SPI clock as seen by the card
//   miso   in   card data out
//   ctl    sd_resp_rx_if.slave (arm, long_resp, busy, resp_valid,
//          resp_timeout, resp, and r1_err when SD_RESP_R1_ERRCHK_EN is defined)
// Parameters:
//   NCR_MAX     all-ones bytes tolerated after arm before timeout
//   SYNC_STAGES synchroniser depth (>= 2)
// Optional: define SD_RESP_R1_ERRCHK_EN to add ctl.r1_err.
// -----------------------------------------------------------------------------
module sd_resp_rx
    import sd_pkg::*;
#(
    parameter int NCR_MAX     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sclk,
    input  logic          miso,
    sd_resp_rx_if.slave   ctl
);

    localparam int BYTE_W = $clog2(NCR_MAX + 1);
    localparam logic [BYTE_W-1:0] BYTE_ONE  = BYTE_W'(32'd1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NCR_MAX - 1);

    logic sclk_s;
    logic sclk_rise_s;
    logic miso_s;
    logic miso_rise_unused_s;

    sd_rx_state_t      state_r;
    logic              long_r;
    logic [5:0]        bitcnt_r;
    logic [BYTE_W-1:0] bytecnt_r;
    logic              busy_r;
    logic              resp_valid_r;
    logic              resp_timeout_r;
    logic [RESP_W-1:0] resp_r;
`ifdef SD_RESP_R1_ERRCHK_EN
    logic              r1_err_r;
`endif

    sd_edge_sync #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (sclk),
        .q    (sclk_s),
        .rise (sclk_rise_s)
    );

    // miso only needs the level; its edge output is not used
    sd_edge_sync #(.STAGES(SYNC_STAGES)) u_miso_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (miso),
        .q    (miso_s),
        .rise (miso_rise_unused_s)
    );

    // Receiver FSM: hunt for the start bit, shift in R1 and the optional word
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            long_r         <= 1'b0;
            bitcnt_r       <= 6'd0;
            bytecnt_r      <= {BYTE_W{1'b0}};
            busy_r         <= 1'b0;
            resp_valid_r   <= 1'b0;
            resp_timeout_r <= 1'b0;
            resp_r         <= {RESP_W{1'b0}};
`ifdef SD_RESP_R1_ERRCHK_EN
            r1_err_r       <= 1'b0;
`endif
        end else begin
            resp_valid_r   <= 1'b0;
            resp_timeout_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    busy_r <= 1'b0;
                    // An sclk edge in the arm cycle is deliberately not sampled
                    if (ctl.arm) begin
                        long_r    <= ctl.long_resp;
                        resp_r    <= {RESP_W{1'b0}};
                        bitcnt_r  <= 6'd0;
                        bytecnt_r <= {BYTE_W{1'b0}};
                        busy_r    <= 1'b1;
`ifdef SD_RESP_R1_ERRCHK_EN
                        r1_err_r  <= 1'b0;
`endif
                        state_r   <= HUNT;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                HUNT: begin
                    if (sclk_rise_s) begin
                        if (miso_s == 1'b0) begin
                            // Start bit doubles as R1 bit 7
                            resp_r[R1_MSB:R1_LSB] <= {resp_r[R1_MSB-1:R1_LSB], 1'b0};
                            bitcnt_r <= 6'd1;
                            state_r  <= R1;
                        end else if (bitcnt_r == 6'd7) begin
                            // Eighth one in a row closes an Ncr byte
                            bitcnt_r  <= 6'd0;
                            bytecnt_r <= bytecnt_r + BYTE_ONE;
                            if (bytecnt_r == BYTE_LAST) begin
                                resp_r         <= RESP_TIMEOUT_FILL;
                                resp_timeout_r <= 1'b1;
                                busy_r         <= 1'b0;
                                state_r        <= IDLE;
                            end else begin
                                state_r        <= HUNT;
                            end
                        end else begin
                            bitcnt_r <= bitcnt_r + 6'd1;
                        end
                    end else begin
                        state_r <= HUNT;
                    end
                end
                R1: begin
                    if (sclk_rise_s) begin
                        resp_r[R1_MSB:R1_LSB] <= {resp_r[R1_MSB-1:R1_LSB], miso_s};
                        if (bitcnt_r == 6'd7) begin
                            bitcnt_r <= 6'd0;
                            state_r  <= long_r ? EXTRA : DONE;
                        end else begin
                            bitcnt_r <= bitcnt_r + 6'd1;
                        end
                    end else begin
                        state_r <= R1;
                    end
                end
                EXTRA: begin
                    if (sclk_rise_s) begin
                        resp_r[EXTRA_W-1:0] <= {resp_r[EXTRA_W-2:0], miso_s};
                        if (bitcnt_r == 6'd31) begin
                            bitcnt_r <= 6'd0;
                            state_r  <= DONE;
                        end else begin
                            bitcnt_r <= bitcnt_r + 6'd1;
                        end
                    end else begin
                        state_r <= EXTRA;
                    end
                end
                DONE: begin
                    resp_valid_r <= 1'b1;
                    busy_r       <= 1'b0;
`ifdef SD_RESP_R1_ERRCHK_EN
                    r1_err_r     <= r1_err_flag(resp_r[R1_MSB:R1_LSB]);
`endif
                    state_r      <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign ctl.busy         = busy_r;
    assign ctl.resp_valid   = resp_valid_r;
    assign ctl.resp_timeout = resp_timeout_r;
    assign ctl.resp         = resp_r;
`ifdef SD_RESP_R1_ERRCHK_EN
    assign ctl.r1_err       = r1_err_r;
`endif

endmodule

// File: tb/tb_sd_resp_rx.sv
// -----------------------------------------------------------------------------
// tb_sd_resp_rx
// Directed bench for sd_resp_rx: R1, R7, timeout, reset mid-response,
// arm-while-busy with a stalled sclk, and R1 error flag when enabled.
// -----------------------------------------------------------------------------
module tb_sd_resp_rx;
    import sd_pkg::*;

    logic clk;
    logic rst;
    logic sclk;
    logic miso;

    int checks;
    int errors;
    int valid_cnt;
    int to_cnt;
    int overlap_cnt;

    sd_resp_rx_if ifc ();

    sd_resp_rx #(.NCR_MAX(8), .SYNC_STAGES(2)) dut (
        .clk  (clk),
        .rst  (rst),
        .sclk (sclk),
        .miso (miso),
        .ctl  (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters, sampled on the active edge
    always @(posedge clk) begin
        if (ifc.resp_valid)   valid_cnt <= valid_cnt + 1;
        if (ifc.resp_timeout) to_cnt    <= to_cnt + 1;
        if (ifc.resp_valid && ifc.resp_timeout) overlap_cnt <= overlap_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One SPI bit: data set while sclk low, sampled on the rising edge
    task automatic send_bit(input logic b);
        miso = b;
        repeat (4) @(negedge clk);
        sclk = 1'b1;
        repeat (4) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic arm_pulse(input logic lng);
        @(negedge clk);
        ifc.arm       = 1'b1;
        ifc.long_resp = lng;
        @(negedge clk);
        ifc.arm       = 1'b0;
        ifc.long_resp = 1'b0;
    endtask

    // Wait (bounded) for either result pulse, then let things settle
    task automatic wait_result(input string tag, input int vb, input int tb);
        int n;
        n = 0;
        while (valid_cnt == vb && to_cnt == tb && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(n < 200), 64'd1);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int vb;
        int tb;
        checks = 0; errors = 0;
        valid_cnt = 0; to_cnt = 0; overlap_cnt = 0;
        rst = 1'b1; sclk = 1'b0; miso = 1'b1;
        ifc.arm = 1'b0; ifc.long_resp = 1'b0;
        repeat (5) @(negedge clk);

        // Reset state
        chk("rst_busy",  64'(ifc.busy), 64'd0);
        chk("rst_valid", 64'(ifc.resp_valid), 64'd0);
        chk("rst_to",    64'(ifc.resp_timeout), 64'd0);
        chk("rst_resp",  64'(ifc.resp), 64'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // R1 only: two Ncr bytes then 0x01
        vb = valid_cnt; tb = to_cnt;
        arm_pulse(1'b0);
        chk("r1_busy_on", 64'(ifc.busy), 64'd1);
        send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h01);
        wait_result("r1_wait", vb, tb);
        chk("r1_resp",   64'(ifc.resp), 64'h01_0000_0000);
        chk("r1_pulses", 64'(valid_cnt - vb), 64'd1);
        chk("r1_no_to",  64'(to_cnt - tb), 64'd0);
        chk("r1_busy",   64'(ifc.busy), 64'd0);
        repeat (10) @(negedge clk);
        chk("r1_hold",   64'(ifc.resp), 64'h01_0000_0000);

        // R7: one Ncr byte then 01 00 00 01 AA
        vb = valid_cnt; tb = to_cnt;
        arm_pulse(1'b1);
        chk("r7_clr",    64'(ifc.resp), 64'd0);
        send_byte(8'hFF); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h01); send_byte(8'hAA);
        wait_result("r7_wait", vb, tb);
        chk("r7_resp",   64'(ifc.resp), 64'h01_0000_01AA);
        chk("r7_pulses", 64'(valid_cnt - vb), 64'd1);
        chk("r7_busy",   64'(ifc.busy), 64'd0);

        // Timeout: 63 ones are tolerated, the 64th times out
        vb = valid_cnt; tb = to_cnt;
        arm_pulse(1'b0);
        for (int i = 0; i < 63; i++) send_bit(1'b1);
        repeat (6) @(negedge clk);
        chk("to_early",  64'(to_cnt - tb), 64'd0);
        chk("to_busy63", 64'(ifc.busy), 64'd1);
        send_bit(1'b1);
        wait_result("to_wait", vb, tb);
        chk("to_pulses", 64'(to_cnt - tb), 64'd1);
        chk("to_novalid", 64'(valid_cnt - vb), 64'd0);
        chk("to_resp",   64'(ifc.resp), 64'hFF_FFFF_FFFF);
        chk("to_busy",   64'(ifc.busy), 64'd0);

        // Reset after 12 bits of an R7
        vb = valid_cnt; tb = to_cnt;
        arm_pulse(1'b1);
        send_byte(8'h01);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        repeat (4) @(negedge clk);
        chk("rst_mid_resp_pre", 64'(ifc.resp), 64'h01_0000_0000);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy", 64'(ifc.busy), 64'd0);
        chk("rst_mid_resp", 64'(ifc.resp), 64'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("rst_mid_nopulse", 64'((valid_cnt - vb) + (to_cnt - tb)), 64'd0);
        miso = 1'b1;
        arm_pulse(1'b0);
        send_byte(8'h00);
        wait_result("rearm_wait", vb, tb);
        chk("rearm_resp",  64'(ifc.resp), 64'h00_0000_0000);
        chk("rearm_valid", 64'(valid_cnt - vb), 64'd1);

        // Arm while busy is ignored; stalled sclk never times out
        vb = valid_cnt; tb = to_cnt;
        arm_pulse(1'b0);
        send_byte(8'hFF);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        arm_pulse(1'b1);
        chk("busy_arm_busy", 64'(ifc.busy), 64'd1);
        repeat (1000) @(negedge clk);
        chk("stall_no_to",    64'(to_cnt - tb), 64'd0);
        chk("stall_no_valid", 64'(valid_cnt - vb), 64'd0);
        chk("stall_busy",     64'(ifc.busy), 64'd1);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        wait_result("stall_wait", vb, tb);
        chk("stall_resp",  64'(ifc.resp), 64'h01_0000_0000);
        chk("stall_valid", 64'(valid_cnt - vb), 64'd1);

`ifdef SD_RESP_R1_ERRCHK_EN
        // R1 error flag: illegal command + idle, then idle only
        vb = valid_cnt; tb = to_cnt;
        arm_pulse(1'b0);
        send_byte(8'hFF); send_byte(8'h05);
        wait_result("err_wait", vb, tb);
        chk("err_resp", 64'(ifc.resp), 64'h05_0000_0000);
        chk("err_set",  64'(ifc.r1_err), 64'd1);
        vb = valid_cnt; tb = to_cnt;
        arm_pulse(1'b0);
        chk("err_clr_arm", 64'(ifc.r1_err), 64'd0);
        send_byte(8'h01);
        wait_result("ok_wait", vb, tb);
        chk("err_idle_only", 64'(ifc.r1_err), 64'd0);
`endif

        chk("no_overlap", 64'(overlap_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
